// File: rtl/spi_dac_if.sv
// Serial DAC link: the three asynchronous serial inputs and the decoded register outputs.
// The receiver drives the outputs through the slave modport; a host or bench drives the master side.
interface spi_dac_if #(
  parameter int WORD_BITS = 16
);
  logic                 cs;
  logic                 dclk;
  logic                 data;
  logic [WORD_BITS-1:0] word;
  logic                 word_valid;
  logic                 frame_err;
  logic [11:0]          x_val;
  logic [11:0]          y_val;
  logic [15:0]          frame_count;

  modport master (
    output cs, dclk, data,
    input  word, word_valid, frame_err, x_val, y_val, frame_count
  );

  modport slave (
    input  cs, dclk, data,
    output word, word_valid, frame_err, x_val, y_val, frame_count
  );
endinterface

// File: rtl/spi_dac_receiver.sv
// SPI-style DAC command receiver: synchronizes cs/dclk/data, shifts MSB-first frames and
// publishes correctly sized words, decoding 16-bit words into channel A/B DAC codes.
module spi_dac_receiver #(
  parameter int WORD_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      reset,
  spi_dac_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_e;

  localparam logic [5:0] CNT_MAX  = 6'd63;
  localparam logic [5:0] CNT_FULL = 6'(WORD_BITS);
  localparam bit         DECODE   = (WORD_BITS == 16);
  localparam int         CH_IDX   = (WORD_BITS >= 16) ? 15 : WORD_BITS - 1;
  localparam int         SHDN_IDX = (WORD_BITS >= 16) ? 12 : 0;

  // Synchronizer chains shift in at bit 0; the MSB is the synchronized copy.
  logic [SYNC_STAGES-1:0] cs_sync_q, dclk_sync_q, data_sync_q;
  logic                   cs_s, dclk_s, data_s;
  logic                   cs_dly_q, dclk_dly_q;
  logic                   cs_edge;
  logic                   cs_fall_q, cs_rise_q, dclk_rise_q, data_smp_q;

  state_e                 state_q, state_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [WORD_BITS-1:0]   word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [11:0]            x_q, x_d;
  logic [11:0]            y_q, y_d;
  logic [15:0]            fc_q, fc_d;

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign dclk_s  = dclk_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign cs_edge = cs_s ^ cs_dly_q;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values
  // and the order of statements inside a clocked block never matters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_q   <= '0;
      dclk_sync_q <= '0;
      data_sync_q <= '0;
      cs_dly_q    <= 1'b0;
      dclk_dly_q  <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      dclk_rise_q <= 1'b0;
      data_smp_q  <= 1'b0;
    end else begin
      cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(bus.cs);
      dclk_sync_q <= (dclk_sync_q << 1) | SYNC_STAGES'(bus.dclk);
      data_sync_q <= (data_sync_q << 1) | SYNC_STAGES'(bus.data);
      cs_dly_q    <= cs_s;
      dclk_dly_q  <= dclk_s;
      // Edges are registered once more; a dclk edge coinciding with any cs edge is dropped.
      cs_fall_q   <= cs_dly_q & ~cs_s;
      cs_rise_q   <= cs_s & ~cs_dly_q;
      dclk_rise_q <= dclk_s & ~dclk_dly_q & ~cs_edge;
      data_smp_q  <= data_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      fc_q         <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      x_q          <= x_d;
      y_q          <= y_d;
      fc_q         <= fc_d;
    end
  end

  // NOTE: every signal gets a default at the top of this block so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    fc_d         = fc_q;

    unique case (state_q)
      // Wait for cs to be seen high so a frame already running at reset release is skipped.
      WAIT_IDLE: begin
        if (cs_s) state_d = IDLE;
      end

      IDLE: begin
        if (cs_fall_q) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end

      SHIFT: begin
        if (cs_rise_q) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            word_d       = shift_q;
            word_valid_d = 1'b1;
            fc_d         = fc_q + 16'd1;
            if (DECODE && shift_q[SHDN_IDX]) begin
              if (shift_q[CH_IDX]) y_d = 12'(shift_q);
              else                 x_d = 12'(shift_q);
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (dclk_rise_q) begin
          shift_d = (shift_q << 1) | WORD_BITS'(data_smp_q);
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 6'd1;
        end
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  assign bus.word        = word_q;
  assign bus.word_valid  = word_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.x_val       = x_q;
  assign bus.y_val       = y_q;
  assign bus.frame_count = fc_q;

endmodule
